// File: rtl/serdes_pkg.sv
// Shared SerDes definitions: link states, default framing word and a
// counter-width helper used by both the RX deserialiser and the TX framer.
package serdes_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } link_state_e;

    localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;

    // Bits needed for a counter that must hold values 0..max_val (at least 1 bit).
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end else begin
            return $clog2(max_val + 1);
        end
    endfunction

endpackage

// File: rtl/deser_link_ctrl_if.sv
// Downstream payload handshake: the deserialiser drives data/valid,
// the RX packet logic drives ready.
interface deser_link_ctrl_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/deser_shift_window.sv
// LSB-first shift window with a framing-word comparator. next_word is the
// value the window takes on the coming edge, so decisions in the parent
// see the completed word on the same edge that shifts its last bit in.
module deser_shift_window
    import serdes_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(DEFAULT_SYNC_WORD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    output logic [WIDTH-1:0] next_word,
    output logic             sync_hit
);

    logic [WIDTH-1:0] win_q;
    logic [WIDTH-1:0] win_d;

    // New bit enters at the MSB so the first received bit ends up at bit 0.
    always_comb begin
        win_d = {serial_in, win_q[WIDTH-1:1]};
    end

    // Window register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q <= '0;
        end else begin
            win_q <= win_d;
        end
    end

    assign next_word = win_d;
    assign sync_hit  = (win_d == SYNC_WORD);

endmodule

// File: rtl/deser_link_ctrl.sv
// Receive-side link controller: hunts for the framing word, verifies
// alignment, declares/drops lock and hands payload words downstream.
module deser_link_ctrl
    import serdes_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD   = WIDTH'(DEFAULT_SYNC_WORD),
    parameter int               PAYLOAD_LEN = 4,
    parameter int               LOCK_COUNT  = 4,
    parameter int               LOSS_COUNT  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                serial_in,
    input  logic                enable,
    deser_link_ctrl_if.master   link,
    output logic                locked,
    output logic                overflow,
    output logic [1:0]          state_o
);

    localparam int BIT_W  = cnt_width(WIDTH - 1);
    localparam int IDX_W  = cnt_width(PAYLOAD_LEN);
    localparam int GOOD_W = cnt_width(LOCK_COUNT);
    localparam int MISS_W = cnt_width(LOSS_COUNT);

    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0]  IDX_SYNC  = IDX_W'(PAYLOAD_LEN);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_COUNT);
    localparam logic [MISS_W-1:0] MISS_LOSS = MISS_W'(LOSS_COUNT);

    logic [WIDTH-1:0]  next_word;
    logic              sync_hit;

    link_state_e       state_q,    state_d;
    logic [BIT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic [IDX_W-1:0]  word_idx_q, word_idx_d;
    logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
    logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              locked_q,   locked_d;
    logic              overflow_q, overflow_d;
    logic [GOOD_W-1:0] good_inc;
    logic [MISS_W-1:0] miss_inc;

    deser_shift_window #(
        .WIDTH     (WIDTH),
        .SYNC_WORD (SYNC_WORD)
    ) u_window (
        .clk       (clk),
        .rst       (rst),
        .serial_in (serial_in),
        .next_word (next_word),
        .sync_hit  (sync_hit)
    );

    // Next-state, alignment counters and delivery/overflow decisions.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        word_idx_d  = word_idx_q;
        good_cnt_d  = good_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        out_data_d  = out_data_q;
        overflow_d  = overflow_q;
        good_inc    = good_cnt_q + GOOD_W'(1);
        miss_inc    = miss_cnt_q + MISS_W'(1);

        // Consumer handshake runs regardless of link state.
        if (out_valid_q && link.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (!enable) begin
            state_d    = ST_HUNT;
            bit_cnt_d  = '0;
            word_idx_d = '0;
            good_cnt_d = '0;
            miss_cnt_d = '0;
        end else begin
            case (state_q)
                ST_HUNT: begin
                    if (sync_hit) begin
                        bit_cnt_d  = '0;
                        word_idx_d = '0;
                        good_cnt_d = GOOD_W'(1);
                        miss_cnt_d = '0;
                        state_d    = (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
                ST_VERIFY, ST_LOCKED: begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        if (word_idx_q == IDX_SYNC) begin
                            word_idx_d = '0;
                            if (state_q == ST_VERIFY) begin
                                if (!sync_hit) begin
                                    state_d    = ST_HUNT;
                                    good_cnt_d = '0;
                                    miss_cnt_d = '0;
                                end else if (good_inc == GOOD_LOCK) begin
                                    state_d    = ST_LOCKED;
                                    good_cnt_d = good_inc;
                                    miss_cnt_d = '0;
                                end else begin
                                    good_cnt_d = good_inc;
                                end
                            end else begin
                                if (sync_hit) begin
                                    miss_cnt_d = '0;
                                end else if (miss_inc == MISS_LOSS) begin
                                    // Lock lost: counters restart for a fresh hunt.
                                    state_d    = ST_HUNT;
                                    good_cnt_d = '0;
                                    miss_cnt_d = '0;
                                end else begin
                                    // Alignment is kept on a miss; only the count moves.
                                    miss_cnt_d = miss_inc;
                                end
                            end
                        end else begin
                            word_idx_d = word_idx_q + IDX_W'(1);
                            if (state_q == ST_LOCKED) begin
                                if (out_valid_q && !link.out_ready) begin
                                    overflow_d = 1'b1;
                                end else begin
                                    out_data_d  = next_word;
                                    out_valid_d = 1'b1;
                                end
                            end else begin
                                out_data_d = out_data_q;
                            end
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
                default: begin
                    state_d    = ST_HUNT;
                    bit_cnt_d  = '0;
                    word_idx_d = '0;
                    good_cnt_d = '0;
                    miss_cnt_d = '0;
                end
            endcase
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            bit_cnt_q   <= '0;
            word_idx_q  <= '0;
            good_cnt_q  <= '0;
            miss_cnt_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            word_idx_q  <= word_idx_d;
            good_cnt_q  <= good_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            locked_q    <= locked_d;
            overflow_q  <= overflow_d;
        end
    end

    assign link.out_data  = out_data_q;
    assign link.out_valid = out_valid_q;
    assign locked         = locked_q;
    assign overflow       = overflow_q;
    assign state_o        = state_q;

endmodule
